instr_buffer: RTL

//  Fetch-side instruction queue: consumer end of the IF1 PC/valid stream. Takes {pc,instr} from IF2/ICache,

---
 rtl/if_pkg.sv | 11 +
 rtl/instr_buffer_mem.sv | 24 ++
 rtl/instr_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Fetch-path types shared by IF1, IF2, the instruction buffer and ID.
package if_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/instr_buffer_mem.sv
// DEPTH-entry storage for the instruction buffer: one write port, asynchronous read.
module instr_buffer_mem
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_pkt_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_pkt_t               rdata
);

  fetch_pkt_t mem_q [DEPTH];

  // Unreset storage: readers gate the output with occupancy.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_buffer.sv
// In-order fetch queue between IF2 and ID with early-stall slack for IF1.
// Optional same-cycle empty-queue bypass enabled by defining INSTR_BUF_BYPASS_EN.
module instr_buffer
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SLACK = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [INSTR_W-1:0]           in_pc,
  input  logic [INSTR_W-1:0]           in_instr,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [INSTR_W-1:0]           out_pc,
  output logic [INSTR_W-1:0]           out_instr,
  output logic                         stall_full_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SLACK);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  fetch_pkt_t in_pkt, head_pkt;
  logic has_data, full, bypass, deq, enq, bypass_take, push, pop;

  assign in_pkt   = '{pc: in_pc, instr: in_instr};
  assign has_data = (count_q != '0);
  assign full     = (count_q == FULL_CNT);

`ifdef INSTR_BUF_BYPASS_EN
  assign bypass    = ~has_data & in_valid & ~flush;
  assign out_valid = has_data | bypass;
  assign out_pc    = has_data ? head_pkt.pc    : (bypass ? in_pc    : '0);
  assign out_instr = has_data ? head_pkt.instr : (bypass ? in_instr : '0);
`else
  assign bypass    = 1'b0;
  assign out_valid = has_data;
  assign out_pc    = has_data ? head_pkt.pc    : '0;
  assign out_instr = has_data ? head_pkt.instr : '0;
`endif

  assign deq = out_valid & out_ready;
  assign enq = in_valid & ~flush & (~full | deq);
  // A bypassed beat consumed this cycle is neither stored nor popped.
  assign bypass_take = bypass & out_ready;
  assign push        = enq & ~bypass_take;
  assign pop         = deq & ~bypass_take;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (in_valid && full && !deq) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  instr_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_pkt),
    .raddr (rd_ptr_q),
    .rdata (head_pkt)
  );

  assign stall_full_instr = (count_q >= STALL_CNT);
  assign count            = count_q;
  assign ovf_err          = ovf_q;

endmodule
